// File: rtl/rholang_ccn_pkg.sv
// Shared types and widths for the CCN receive path of each FPU.
package rholang_ccn_pkg;

    localparam int CH_W  = 8;
    localparam int MSG_W = 32;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } recv_state_t;

    typedef struct packed {
        logic             valid;
        logic [CH_W-1:0]  channel_id;
        logic [MSG_W-1:0] message;
    } recv_entry_t;

endpackage

// File: rtl/recv_match_prio_enc.sv
// Lowest-index priority encoder over (valid & match) bits.
// Purely combinational; also used by the send-side lookup.
module recv_match_prio_enc #(
    parameter int  DEPTH = 8,
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [DEPTH-1:0] valid_i,
    input  logic [DEPTH-1:0] match_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] hit_idx_o
);

    // Walk from the top down so the lowest qualifying index wins.
    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_i[i] && match_i[i]) begin
                hit_o     = 1'b1;
                hit_idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/fpu_recv_match_buffer.sv
// Per-FPU receive buffer: absorbs CCN deliveries into an age-ordered
// compacting queue and serves blocking receive-on-channel requests with
// the oldest matching message.
module fpu_recv_match_buffer #(
    parameter int DEPTH = 8,
    parameter int CH_W  = 8,
    parameter int MSG_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CH_W-1:0]  ccn_recv_channel_id,
    input  logic [MSG_W-1:0] ccn_recv_message,
    input  logic             ccn_recv_valid,
    output logic             ccn_recv_ready,
    input  logic             req_valid,
    input  logic [CH_W-1:0]  req_channel_id,
    output logic             req_ready,
    input  logic             req_cancel,
    output logic             rsp_valid,
    output logic [CH_W-1:0]  rsp_channel_id,
    output logic [MSG_W-1:0] rsp_message,
    input  logic             rsp_ready,
    output logic [4:0]       debug_occupancy,
    output logic             debug_overflow,
    output logic [1:0]       debug_state
);

    import rholang_ccn_pkg::*;

    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    // Same layout as recv_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic             valid;
        logic [CH_W-1:0]  channel_id;
        logic [MSG_W-1:0] message;
    } entry_t;

    entry_t           ent_q [DEPTH];
    entry_t           ent_d [DEPTH];
    logic [4:0]       count_q, count_d, cnt_rm;
    recv_state_t      state_q, state_d;
    logic [CH_W-1:0]  chan_q, chan_d;
    logic [CH_W-1:0]  rsp_ch_q, rsp_ch_d;
    logic [MSG_W-1:0] rsp_msg_q, rsp_msg_d;
    logic             ovf_q, ovf_d;
    logic             hit_q, scan_vld_q, scan_vld_d;
    logic [IDX_W-1:0] idx_q;
    logic             remove, ins_ok;

    logic [DEPTH-1:0] valid_vec, match_vec;
    logic             scan_hit;
    logic [IDX_W-1:0] scan_idx;

    // Match vector over registered entries only; a same-cycle arrival is
    // seen by the scan one cycle later.
    always_comb begin
        valid_vec = '0;
        match_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = ent_q[i].valid;
            match_vec[i] = (ent_q[i].channel_id == chan_q);
        end
    end

    recv_match_prio_enc #(.DEPTH(DEPTH)) u_prio (
        .valid_i   (valid_vec),
        .match_i   (match_vec),
        .hit_o     (scan_hit),
        .hit_idx_o (scan_idx)
    );

    // Request FSM. The scan result is registered, so the encoder never sits
    // in front of the shift network. scan_vld_q marks a result that was
    // computed against the currently latched channel.
    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        rsp_ch_d   = rsp_ch_q;
        rsp_msg_d  = rsp_msg_q;
        scan_vld_d = 1'b1;
        remove     = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    chan_d     = req_channel_id;
                    scan_vld_d = 1'b0;
                    state_d    = SEARCH;
                end
            end
            SEARCH, WAIT: begin
                if (req_cancel) begin
                    state_d = IDLE;
                end else if ((state_q == WAIT || scan_vld_q) && hit_q) begin
                    remove    = 1'b1;
                    rsp_ch_d  = ent_q[idx_q].channel_id;
                    rsp_msg_d = ent_q[idx_q].message;
                    state_d   = RESP;
                end else if (scan_vld_q) begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Buffer next state: compact above the removed slot, then append at the
    // post-removal tail so a same-cycle insert+remove keeps count steady.
    always_comb begin
        ins_ok  = ccn_recv_valid && ((count_q < DEPTH_C) || remove);
        ovf_d   = ovf_q | (ccn_recv_valid && (count_q >= DEPTH_C) && !remove);
        cnt_rm  = count_q - {4'b0, remove};
        count_d = cnt_rm + {4'b0, ins_ok};
        for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (remove && (i >= int'(idx_q))) ent_d[i] = ent_q[i+1];
        end
        if (remove) ent_d[DEPTH-1] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ins_ok && (cnt_rm == 5'(i))) begin
                ent_d[i] = '{valid: 1'b1, channel_id: ccn_recv_channel_id,
                             message: ccn_recv_message};
            end
        end
    end

    // State, buffer and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            chan_q     <= '0;
            rsp_ch_q   <= '0;
            rsp_msg_q  <= '0;
            ovf_q      <= 1'b0;
            hit_q      <= 1'b0;
            idx_q      <= '0;
            scan_vld_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            chan_q     <= chan_d;
            rsp_ch_q   <= rsp_ch_d;
            rsp_msg_q  <= rsp_msg_d;
            ovf_q      <= ovf_d;
            hit_q      <= scan_hit;
            idx_q      <= scan_idx;
            scan_vld_q <= scan_vld_d;
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
        end
    end

    assign ccn_recv_ready  = (count_q < DEPTH_C);
    assign rsp_channel_id  = rsp_ch_q;
    assign rsp_message     = rsp_msg_q;
    assign debug_occupancy = count_q;
    assign debug_overflow  = ovf_q;
    assign debug_state     = state_q;

endmodule

// File: tb/tb_fpu_recv_match_buffer.sv
// Directed bench for fpu_recv_match_buffer (DEPTH=8). Inputs change and
// outputs are sampled on the falling edge.
module tb_fpu_recv_match_buffer;

    localparam int DEPTH = 8;
    localparam int CH_W  = 8;
    localparam int MSG_W = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [CH_W-1:0]  ccn_recv_channel_id = '0;
    logic [MSG_W-1:0] ccn_recv_message = '0;
    logic             ccn_recv_valid = 1'b0;
    logic             ccn_recv_ready;
    logic             req_valid = 1'b0;
    logic [CH_W-1:0]  req_channel_id = '0;
    logic             req_ready;
    logic             req_cancel = 1'b0;
    logic             rsp_valid;
    logic [CH_W-1:0]  rsp_channel_id;
    logic [MSG_W-1:0] rsp_message;
    logic             rsp_ready = 1'b0;
    logic [4:0]       debug_occupancy;
    logic             debug_overflow;
    logic [1:0]       debug_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fpu_recv_match_buffer #(.DEPTH(DEPTH), .CH_W(CH_W), .MSG_W(MSG_W)) dut (
        .clk                 (clk),
        .reset               (reset),
        .ccn_recv_channel_id (ccn_recv_channel_id),
        .ccn_recv_message    (ccn_recv_message),
        .ccn_recv_valid      (ccn_recv_valid),
        .ccn_recv_ready      (ccn_recv_ready),
        .req_valid           (req_valid),
        .req_channel_id      (req_channel_id),
        .req_ready           (req_ready),
        .req_cancel          (req_cancel),
        .rsp_valid           (rsp_valid),
        .rsp_channel_id      (rsp_channel_id),
        .rsp_message         (rsp_message),
        .rsp_ready           (rsp_ready),
        .debug_occupancy     (debug_occupancy),
        .debug_overflow      (debug_overflow),
        .debug_state         (debug_state)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic deliver(input logic [CH_W-1:0] ch, input logic [MSG_W-1:0] msg);
        ccn_recv_valid      = 1'b1;
        ccn_recv_channel_id = ch;
        ccn_recv_message    = msg;
        tick();
        ccn_recv_valid = 1'b0;
    endtask

    // Present a request for one cycle; returns just after the accept edge.
    task automatic accept(input logic [CH_W-1:0] ch);
        req_valid      = 1'b1;
        req_channel_id = ch;
        tick();
        req_valid = 1'b0;
    endtask

    // Request with the match already buffered: response two edges after accept.
    task automatic do_req(input string tag, input logic [CH_W-1:0] ch, input logic [MSG_W-1:0] msg);
        accept(ch);
        chk({tag, "_st_search"}, 64'(debug_state), 64'd1);
        tick();
        chk({tag, "_rsp_n1"}, 64'(rsp_valid), 64'd0);
        tick();
        chk({tag, "_rsp_n2"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_ch"}, 64'(rsp_channel_id), 64'(ch));
        chk({tag, "_msg"}, 64'(rsp_message), 64'(msg));
    endtask

    task automatic consume(input string tag);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_clr"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_idle"}, 64'(debug_state), 64'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_ch", 64'(rsp_channel_id), 64'd0);
        chk("rst_rsp_msg", 64'(rsp_message), 64'd0);
        chk("rst_occ", 64'(debug_occupancy), 64'd0);
        chk("rst_ovf", 64'(debug_overflow), 64'd0);
        chk("rst_state", 64'(debug_state), 64'd0);
        chk("rst_ccn_rdy", 64'(ccn_recv_ready), 64'd1);
        chk("rst_req_rdy", 64'(req_ready), 64'd1);
        reset = 1'b1;
        tick();

        // Per-channel FIFO order, out of order across channels
        deliver(8'd5, 32'hA);
        deliver(8'd7, 32'hB);
        deliver(8'd5, 32'hC);
        chk("fifo_occ3", 64'(debug_occupancy), 64'd3);
        do_req("fifo_a", 8'd5, 32'hA);
        chk("fifo_occ2", 64'(debug_occupancy), 64'd2);
        consume("fifo_a");
        do_req("fifo_c", 8'd5, 32'hC);
        chk("fifo_occ1", 64'(debug_occupancy), 64'd1);
        consume("fifo_c");

        // Waiting request satisfied by a later delivery
        accept(8'd9);
        tick();
        tick();
        chk("wait_state", 64'(debug_state), 64'd2);
        chk("wait_norsp", 64'(rsp_valid), 64'd0);
        deliver(8'd9, 32'h55);
        chk("wait_m0", 64'(rsp_valid), 64'd0);
        chk("wait_occ", 64'(debug_occupancy), 64'd2);
        tick();
        chk("wait_m1", 64'(rsp_valid), 64'd0);
        tick();
        chk("wait_m2", 64'(rsp_valid), 64'd1);
        chk("wait_msg", 64'(rsp_message), 64'h55);
        chk("wait_ch", 64'(rsp_channel_id), 64'd9);
        chk("wait_occ_after", 64'(debug_occupancy), 64'd1);
        consume("wait");

        // Fill to DEPTH, then remove entry 3 while a delivery lands
        for (int k = 0; k < 7; k++) deliver(8'(8'h20 + k), 32'(32'h120 + k));
        chk("full_occ", 64'(debug_occupancy), 64'd8);
        chk("full_rdy", 64'(ccn_recv_ready), 64'd0);
        accept(8'h22);
        tick();
        ccn_recv_valid      = 1'b1;
        ccn_recv_channel_id = 8'h30;
        ccn_recv_message    = 32'h130;
        tick();
        ccn_recv_valid = 1'b0;
        chk("same_rsp", 64'(rsp_valid), 64'd1);
        chk("same_msg", 64'(rsp_message), 64'h122);
        chk("same_occ", 64'(debug_occupancy), 64'd8);
        chk("same_ovf", 64'(debug_overflow), 64'd0);
        consume("same");
        do_req("tail", 8'h30, 32'h130);
        chk("tail_occ", 64'(debug_occupancy), 64'd7);
        consume("tail");

        // Overflow: drop while full, contents intact
        deliver(8'h31, 32'h131);
        chk("ovf_full_rdy", 64'(ccn_recv_ready), 64'd0);
        deliver(8'h31, 32'h999);
        chk("ovf_flag", 64'(debug_overflow), 64'd1);
        chk("ovf_occ", 64'(debug_occupancy), 64'd8);
        do_req("ovf_keep", 8'h31, 32'h131);
        chk("ovf_keep_occ", 64'(debug_occupancy), 64'd7);
        consume("ovf_keep");

        // Cancel in WAIT together with a matching arrival
        accept(8'd2);
        tick();
        tick();
        chk("cxl_wait", 64'(debug_state), 64'd2);
        req_cancel          = 1'b1;
        ccn_recv_valid      = 1'b1;
        ccn_recv_channel_id = 8'd2;
        ccn_recv_message    = 32'h222;
        tick();
        req_cancel     = 1'b0;
        ccn_recv_valid = 1'b0;
        chk("cxl_idle", 64'(debug_state), 64'd0);
        chk("cxl_occ", 64'(debug_occupancy), 64'd8);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("cxl_norsp", 64'(rsp_valid), 64'd0);
        end
        do_req("cxl_kept", 8'd2, 32'h222);
        chk("cxl_kept_occ", 64'(debug_occupancy), 64'd7);
        consume("cxl_kept");

        // Cancel on the very cycle a hit would be taken
        accept(8'h20);
        tick();
        req_cancel = 1'b1;
        tick();
        req_cancel = 1'b0;
        chk("cxl_hit_idle", 64'(debug_state), 64'd0);
        chk("cxl_hit_occ", 64'(debug_occupancy), 64'd7);
        chk("cxl_hit_norsp", 64'(rsp_valid), 64'd0);

        // RESP holds under backpressure; reset mid-RESP clears everything
        do_req("hold", 8'd7, 32'hB);
        chk("hold_occ", 64'(debug_occupancy), 64'd6);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_vld", 64'(rsp_valid), 64'd1);
            chk("hold_msg", 64'(rsp_message), 64'hB);
            chk("hold_ch", 64'(rsp_channel_id), 64'd7);
            chk("hold_state", 64'(debug_state), 64'd3);
        end
        reset = 1'b0;
        tick();
        chk("mrst_vld", 64'(rsp_valid), 64'd0);
        chk("mrst_msg", 64'(rsp_message), 64'd0);
        chk("mrst_ch", 64'(rsp_channel_id), 64'd0);
        chk("mrst_occ", 64'(debug_occupancy), 64'd0);
        chk("mrst_state", 64'(debug_state), 64'd0);
        chk("mrst_ovf", 64'(debug_overflow), 64'd0);
        reset = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
